mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter: MULT_CYC, default 5, number of busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 Parameter: DIV_CYC, default 10, number of busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  issue the operation on op this cycle.
REQ-006 Port: op  in  3  operation code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU; codes 5-7 are reserved.
REQ-007 Port: src_a  in  32  rs operand and MTHI/MTLO data.
REQ-008 Port: src_b  in  32  rt operand.
REQ-009 Port: mthi  in  1  write src_a to HI.
REQ-010 Port: mtlo  in  1  write src_a to LO.
REQ-011 Port: flush  in  1  abort the in-flight operation.
REQ-012 Port: busy  out  1  an operation is in flight; the hazard unit stalls MDU/MTHILO/MFHILO instructions in ID while this is high.
REQ-013 Port: done  out  1  one-cycle pulse on the cycle after the result is committed.
REQ-014 Port: hi  out  32  architectural HI register.
REQ-015 Port: lo  out  32  architectural LO register.

Function
REQ-016 The block SHALL use two states: IDLE and BUSY.
REQ-017 In IDLE, start=1 with op 1-4 SHALL latch the result into pending registers, load cycle counter = MULT_CYC or DIV_CYC, and enter BUSY at that edge.
REQ-018 The block SHALL compute the result at issue.
- MULT: {hi,lo} = signed 64-bit product.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- DIVU: unsigned quotient and remainder.
REQ-019 In BUSY, the counter SHALL decrement each cycle; at the edge where counter==1, pending HI/LO SHALL commit, state SHALL return to IDLE, and done SHALL be 1 for the following cycle.
REQ-020 busy SHALL be high for exactly N cycles after the issue edge (N = MULT_CYC or DIV_CYC); new hi/lo SHALL be visible in the first cycle busy is low.
REQ-021 DIV/DIVU with src_b==0 SHALL run the full DIV_CYC busy period and then leave hi/lo unchanged; done still pulses.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-023 start with op 0 or 5-7 SHALL be ignored: no state change, no busy.
REQ-024 In IDLE without a valid start, mthi/mtlo SHALL write src_a to hi/lo at the edge; mthi and mtlo together SHALL write both.
REQ-025 A valid start and mthi/mtlo in the same cycle: start SHALL win and mthi/mtlo SHALL be ignored.
REQ-026 In BUSY, start, mthi and mtlo SHALL be ignored; the hazard unit guarantees they do not occur.
REQ-027 flush in BUSY SHALL discard the pending result, return to IDLE at that edge (busy low next cycle), leave hi/lo unchanged, and suppress done.
REQ-028 flush in IDLE SHALL block any same-cycle start, mthi or mtlo.
REQ-029 flush on the commit edge (counter==1) SHALL take priority: no commit, no done.
REQ-030 busy SHALL be a direct register output with no combinational path from any input.

Reset
REQ-031 rst_n low SHALL immediately, independent of clk, force:
- state IDLE, counter 0
- busy 0, done 0
- hi 0, lo 0, pending registers 0
REQ-032 Reset asserted mid-operation SHALL abort it; no commit occurs after reset releases.
REQ-033 The first edge after rst_n rises SHALL accept start normally.

Verification
REQ-034 MULT 0xFFFFFFFE x 0x00000003 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, one-cycle done.
REQ-035 MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
REQ-036 DIV -7 / 2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> busy 10 cycles, hi/lo unchanged.
REQ-037 MULT issued, flush on its 3rd busy cycle -> busy low next cycle, hi/lo keep prior values, no done; then mthi 0x12345678 -> hi=0x12345678.
REQ-038 DIV issued, rst_n pulsed low on its 4th busy cycle -> busy=0, hi=lo=0 immediately, no later done.
REQ-039 start(MULT) together with mtlo in IDLE -> mtlo ignored, lo = product low word after 5 cycles; mthi asserted during BUSY -> hi unaffected.

Source files
------------

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : HI/LO multiply-divide unit. The result is computed at issue and
//            committed after a fixed busy period.
// Revision : 1.0
// ============================================================================
module mdu_sequencer #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    localparam logic [3:0] MULT_N = 4'(MULT_CYC);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic        pend_wr_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        w_valid_op;
    logic        w_is_div;
    logic        w_is_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_dvs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_valid_op  = (op_i >= OP_MULT) && (op_i <= OP_DIVU);
    assign w_is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign w_is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);

    // Low 64 bits of the product of sign/zero-extended operands serve both MULT and MULTU.
    assign w_ext_a = {(w_is_signed ? {32{src_a_i[31]}} : 32'd0), src_a_i};
    assign w_ext_b = {(w_is_signed ? {32{src_b_i[31]}} : 32'd0), src_b_i};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed division via magnitudes; INT_MIN / -1 wraps to INT_MIN naturally.
    assign w_neg_a = w_is_signed & src_a_i[31];
    assign w_neg_b = w_is_signed & src_b_i[31];
    assign w_mag_a = w_neg_a ? (~src_a_i + 32'd1) : src_a_i;
    assign w_mag_b = w_neg_b ? (~src_b_i + 32'd1) : src_b_i;
    assign w_dvs   = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq    = w_mag_a / w_dvs;
    assign w_ur    = w_mag_a % w_dvs;
    assign w_quo   = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
    assign w_rem   = w_neg_a ? (~w_ur + 32'd1) : w_ur;

    assign w_res_hi = w_is_div ? w_rem : w_prod[63:32];
    assign w_res_lo = w_is_div ? w_quo : w_prod[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else if (start_i && w_valid_op) begin
                        pend_hi_q <= w_res_hi;
                        pend_lo_q <= w_res_lo;
                        pend_wr_q <= !(w_is_div && (src_b_i == 32'd0));
                        cnt_q     <= w_is_div ? DIV_N : MULT_N;
                        busy_q    <= 1'b1;
                        state_q   <= S_BUSY;
                    end else begin
                        if (mthi_i) hi_q <= src_a_i;
                        if (mtlo_i) lo_q <= src_a_i;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        pend_hi_q <= 32'd0;
                        pend_lo_q <= 32'd0;
                        pend_wr_q <= 1'b0;
                        cnt_q     <= 4'd0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == 4'd1) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        pend_wr_q <= 1'b0;
                        cnt_q     <= 4'd0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sequencer
// Purpose  : Directed-vector self-checking bench for mdu_sequencer.
// Revision : 1.0
// ============================================================================
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        mthi_i;
    logic        mtlo_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;

    mdu_sequencer #(.MULT_CYC(5), .DIV_CYC(10)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .op_i    (op_i),
        .src_a_i (src_a_i),
        .src_b_i (src_b_i),
        .mthi_i  (mthi_i),
        .mtlo_i  (mtlo_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        op_i    = 3'd0;
    endtask

    // Counts busy cycles until busy falls, bounded so a stuck DUT cannot hang the run.
    task automatic wait_idle(input int n0, output int n);
        n = n0;
        while (busy_o && n < 40) begin
            step();
            if (busy_o) n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b);
        wait_idle(1, n);
        chk({tag, "_busycyc"}, 32'(n), 32'(exp_n));
        chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
        chk({tag, "_hi"}, hi_o, exp_hi);
        chk({tag, "_lo"}, lo_o, exp_lo);
        step();
        chk({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        int n;
        bit seen_done;

        rst_n   = 1'b0;
        start_i = 1'b0;
        op_i    = 3'd0;
        src_a_i = 32'd0;
        src_b_i = 32'd0;
        mthi_i  = 1'b0;
        mtlo_i  = 1'b0;
        flush_i = 1'b0;
        #12;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        step();
        rst_n = 1'b1;

        // Arithmetic vectors
        run_op("mult",  3'd1, 32'hFFFFFFFE, 32'h00000003, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 3'd2, 32'hFFFFFFFE, 32'h00000003, 5, 32'h00000002, 32'hFFFFFFFA);
        run_op("div",   3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu0", 3'd4, 32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_op("div_negb", 3'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Ignored op codes
        issue(3'd5, 32'd9, 32'd9);
        chk("op5_busy", {31'd0, busy_o}, 32'd0);
        issue(3'd0, 32'd9, 32'd9);
        chk("op0_busy", {31'd0, busy_o}, 32'd0);
        chk("op0_lo", lo_o, 32'd14);

        // MTHI/MTLO in IDLE
        src_a_i = 32'hAAAA5555;
        mthi_i  = 1'b1;
        mtlo_i  = 1'b1;
        step();
        mthi_i  = 1'b0;
        mtlo_i  = 1'b0;
        chk("mthilo_hi", hi_o, 32'hAAAA5555);
        chk("mthilo_lo", lo_o, 32'hAAAA5555);

        // Flush on third busy cycle
        issue(3'd1, 32'd3, 32'd4);
        step();
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_done", {31'd0, done_o}, 32'd0);
        chk("flush_lo", lo_o, 32'hAAAA5555);
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done_o) seen_done = 1'b1;
        end
        chk("flush_nodone", {31'd0, seen_done}, 32'd0);
        chk("flush_hi", hi_o, 32'hAAAA5555);
        src_a_i = 32'h12345678;
        mthi_i  = 1'b1;
        step();
        mthi_i  = 1'b0;
        chk("mthi_after_flush", hi_o, 32'h12345678);

        // Flush in IDLE blocks start and mthi
        flush_i = 1'b1;
        issue(3'd1, 32'd3, 32'd4);
        chk("idleflush_busy", {31'd0, busy_o}, 32'd0);
        src_a_i = 32'h0BADF00D;
        mthi_i  = 1'b1;
        step();
        mthi_i  = 1'b0;
        flush_i = 1'b0;
        chk("idleflush_hi", hi_o, 32'h12345678);

        // Flush on the commit edge
        issue(3'd1, 32'd3, 32'd4);
        repeat (4) step();
        chk("commitflush_pre_busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("commitflush_busy", {31'd0, busy_o}, 32'd0);
        chk("commitflush_done", {31'd0, done_o}, 32'd0);
        chk("commitflush_lo", lo_o, 32'hAAAA5555);

        // start wins over mtlo; mthi during BUSY ignored
        mtlo_i = 1'b1;
        issue(3'd1, 32'd5, 32'd6);
        mtlo_i  = 1'b0;
        src_a_i = 32'hDEADBEEF;
        mthi_i  = 1'b1;
        step();
        mthi_i  = 1'b0;
        wait_idle(2, n);
        chk("mtlo_busycyc", 32'(n), 32'd5);
        chk("mtlo_done", {31'd0, done_o}, 32'd1);
        chk("mtlo_lo", lo_o, 32'd30);
        chk("mthi_busy_hi", hi_o, 32'd0);

        // Reset on the fourth busy cycle of a DIV
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        step();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done_o) seen_done = 1'b1;
        end
        chk("midrst_nodone", {31'd0, seen_done}, 32'd0);
        chk("midrst_lo_after", lo_o, 32'd0);
        run_op("post_rst", 3'd2, 32'd5, 32'd6, 5, 32'd0, 32'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
